id_ex_stage: RTL and testbench

//   ID/EX pipeline register for the 5-stage MIPS core, fed by the main decoder's control word and the register file.

---
 rtl/id_ex_stage.sv | 86 ++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX-side flush, global hold
// and a saturating count of inserted hazard bubbles.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [10:0]      id_ctrl,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [5:0]       id_funct,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ex_valid,
  output logic [10:0]      ex_ctrl,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [5:0]       ex_funct,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int MEMREAD_BIT = 6;

  logic haz;

  // A load in EX whose destination feeds the ID instruction; $0 never counts.
  assign haz = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));

  // A flushed ID instruction is discarded upstream, so it must not stall the front end.
  assign pc_write   = ~hold & ~(haz & ~flush);
  assign ifid_write = pc_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_funct   <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (hold) begin
      ex_valid <= ex_valid;
    end else if (haz) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? id_ctrl : 11'd0;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_funct   <= id_funct;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table with hand expectations, a reference model
// feeding an expected-state queue, a mid-stall reset and a random stream.
module tb_id_ex_stage;

  localparam int DW   = 32;
  localparam int ST_W = 1 + 11 + 4*DW + 15 + 6;
  localparam int SB_W = ST_W + 16 + 2;

  localparam logic [10:0] LW   = 11'b01001100010;
  localparam logic [10:0] RT   = 11'b11000001000;
  localparam logic [10:0] ADDI = 11'b01000000010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hold, flush, id_valid;
  logic [10:0]   id_ctrl;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [5:0]    id_funct;

  logic          pc_write, ifid_write, ex_valid;
  logic [10:0]   ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [5:0]    ex_funct;
  logic [15:0]   bubble_cnt;

  logic          d2_pc_write, d2_ifid_write, d2_ex_valid;
  logic [10:0]   d2_ex_ctrl;
  logic [DW-1:0] d2_ex_pc4, d2_ex_rs_data, d2_ex_rt_data, d2_ex_imm;
  logic [4:0]    d2_ex_rs, d2_ex_rt, d2_ex_rd;
  logic [5:0]    d2_ex_funct;
  logic [1:0]    d2_bubble_cnt;

  // clock / reset
  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .pc_write(pc_write), .ifid_write(ifid_write), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DW(DW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .pc_write(d2_pc_write), .ifid_write(d2_ifid_write), .ex_valid(d2_ex_valid),
    .ex_ctrl(d2_ex_ctrl), .ex_pc4(d2_ex_pc4), .ex_rs_data(d2_ex_rs_data),
    .ex_rt_data(d2_ex_rt_data), .ex_imm(d2_ex_imm), .ex_rs(d2_ex_rs), .ex_rt(d2_ex_rt),
    .ex_rd(d2_ex_rd), .ex_funct(d2_ex_funct), .bubble_cnt(d2_bubble_cnt)
  );

  // reference model of the EX registers
  logic          m_valid;
  logic [10:0]   m_ctrl;
  logic [DW-1:0] m_pc4, m_rs_data, m_rt_data, m_imm;
  logic [4:0]    m_rs, m_rt, m_rd;
  logic [5:0]    m_funct;
  logic [15:0]   m_cnt;
  logic [1:0]    m_cnt2;

  int checks   = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic        hold, flush, vld;
    logic [10:0] ctrl;
    logic [4:0]  rs, rt;
    logic        exp_pcw, exp_valid;
    logic [10:0] exp_ctrl;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic h, logic f, logic v, logic [10:0] c, logic [4:0] rs,
                              logic [4:0] rt, logic pcw, logic ev, logic [10:0] ec,
                              logic [15:0] cnt, logic [1:0] cnt2);
    vec_t r;
    r.hold = h; r.flush = f; r.vld = v; r.ctrl = c; r.rs = rs; r.rt = rt;
    r.exp_pcw = pcw; r.exp_valid = ev; r.exp_ctrl = ec; r.exp_cnt = cnt; r.exp_cnt2 = cnt2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [SB_W-1:0] act, input logic [SB_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [SB_W-1:0] pack_dut();
    return {ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
            ex_funct, bubble_cnt, d2_bubble_cnt};
  endfunction

  function automatic logic [ST_W-1:0] pack_dut2();
    return {d2_ex_valid, d2_ex_ctrl, d2_ex_pc4, d2_ex_rs_data, d2_ex_rt_data, d2_ex_imm,
            d2_ex_rs, d2_ex_rt, d2_ex_rd, d2_ex_funct};
  endfunction

  function automatic logic [SB_W-1:0] pack_model();
    return {m_valid, m_ctrl, m_pc4, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_rd, m_funct,
            m_cnt, m_cnt2};
  endfunction

  function automatic logic model_haz();
    return id_valid & m_valid & m_ctrl[6] & (m_rt != 5'd0) & ((m_rt == id_rs) | (m_rt == id_rt));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_step();
    logic haz;
    haz = model_haz();
    if (flush) begin
      m_valid = 0; m_ctrl = 0;
    end else if (hold) begin
      m_valid = m_valid;
    end else if (haz) begin
      m_valid = 0; m_ctrl = 0;
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end else begin
      m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 11'd0;
      m_pc4 = id_pc4; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct;
    end
  endtask

  // driver: random data payload for the current instruction
  task automatic drive_data();
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rd = 5'($urandom_range(0, 31)); id_funct = 6'($urandom_range(0, 63));
  endtask

  // One clock: inputs already driven; check comb outputs, push expected, compare after edge.
  task automatic run_cycle(input logic hand, input vec_t v);
    logic exp_pcw;
    logic [SB_W-1:0] e;
    #3;
    exp_pcw = ~hold & ~(model_haz() & ~flush);
    chk("pc_write", SB_W'(pc_write), SB_W'(exp_pcw));
    chk("ifid_write", SB_W'(ifid_write), SB_W'(exp_pcw));
    chk("pc_write_w2", SB_W'(d2_pc_write), SB_W'(exp_pcw));
    if (hand) chk("vec_pc_write", SB_W'(pc_write), SB_W'(v.exp_pcw));
    model_step();
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("ex_state", pack_dut(), e);
    chk("ex_state_w2", SB_W'(pack_dut2()), SB_W'(e[SB_W-1:18]));
    chk("ifid_write_w2", SB_W'(d2_ifid_write), SB_W'(d2_pc_write));
    if (hand) begin
      chk("vec_ex_valid", SB_W'(ex_valid), SB_W'(v.exp_valid));
      chk("vec_ex_ctrl", SB_W'(ex_ctrl), SB_W'(v.exp_ctrl));
      chk("vec_bubble_cnt", SB_W'(bubble_cnt), SB_W'(v.exp_cnt));
      chk("vec_bubble_cnt_w2", SB_W'(d2_bubble_cnt), SB_W'(v.exp_cnt2));
    end
  endtask

  vec_t none;

  initial begin
    //                hold flush vld ctrl  rs  rt  pcw ev ectrl cnt cnt2
    vecs[0]  = mk(0, 0, 1, LW,   1, 8, 1, 1, LW,   0, 0);  // lw $8
    vecs[1]  = mk(0, 0, 1, RT,   8, 9, 0, 0, 0,    1, 1);  // use -> bubble
    vecs[2]  = mk(0, 0, 1, RT,   8, 9, 1, 1, RT,   1, 1);  // held add advances
    vecs[3]  = mk(0, 0, 1, LW,   1, 0, 1, 1, LW,   1, 1);  // lw $0
    vecs[4]  = mk(0, 0, 1, RT,   0, 0, 1, 1, RT,   1, 1);  // $0 is not a hazard
    vecs[5]  = mk(0, 0, 1, LW,   1, 8, 1, 1, LW,   1, 1);
    vecs[6]  = mk(0, 1, 1, RT,   8, 9, 1, 0, 0,    1, 1);  // flush wins over haz
    vecs[7]  = mk(0, 0, 1, RT,   8, 9, 1, 1, RT,   1, 1);
    vecs[8]  = mk(0, 0, 1, ADDI, 3, 4, 1, 1, ADDI, 1, 1);  // addi into EX
    vecs[9]  = mk(1, 0, 1, RT,   4, 5, 0, 1, ADDI, 1, 1);  // hold x3
    vecs[10] = mk(1, 0, 1, RT,   4, 5, 0, 1, ADDI, 1, 1);
    vecs[11] = mk(1, 0, 1, RT,   4, 5, 0, 1, ADDI, 1, 1);
    vecs[12] = mk(0, 0, 1, RT,   4, 5, 1, 1, RT,   1, 1);
    vecs[13] = mk(0, 0, 1, LW,   1, 8, 1, 1, LW,   1, 1);
    vecs[14] = mk(1, 0, 1, RT,   8, 2, 0, 1, LW,   1, 1);  // hold + haz: no count
    vecs[15] = mk(0, 0, 1, RT,   8, 2, 0, 0, 0,    2, 2);
    vecs[16] = mk(0, 0, 1, RT,   8, 2, 1, 1, RT,   2, 2);
    vecs[17] = mk(0, 0, 1, LW,   1, 8, 1, 1, LW,   2, 2);  // lw -> lw -> use
    vecs[18] = mk(0, 0, 1, LW,   8, 9, 0, 0, 0,    3, 3);
    vecs[19] = mk(0, 0, 1, LW,   8, 9, 1, 1, LW,   3, 3);
    vecs[20] = mk(0, 0, 1, RT,   9, 2, 0, 0, 0,    4, 3);  // narrow counter saturates
    vecs[21] = mk(0, 0, 1, RT,   9, 2, 1, 1, RT,   4, 3);
    vecs[22] = mk(0, 0, 1, LW,   1, 7, 1, 1, LW,   4, 3);
    vecs[23] = mk(0, 0, 1, RT,   1, 7, 0, 0, 0,    5, 3);  // rt match
    vecs[24] = mk(0, 0, 1, RT,   1, 7, 1, 1, RT,   5, 3);
    vecs[25] = mk(0, 0, 0, RT,   1, 2, 1, 0, 0,    5, 3);  // invalid slot clears ctrl
    vecs[26] = mk(0, 0, 1, LW,   1, 8, 1, 1, LW,   5, 3);
    vecs[27] = mk(0, 0, 0, RT,   8, 2, 1, 0, 0,    5, 3);  // invalid ID never stalls
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // T1: reset held during a random ID stream
    rst_n = 1'b0; hold = 0; flush = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'b1; id_ctrl = 11'($urandom); flush = 1'($urandom_range(0, 1));
      id_rs = 5'($urandom_range(0, 31)); id_rt = 5'($urandom_range(0, 31));
      drive_data();
      @(negedge clk);
      chk("reset_state", pack_dut(), '0);
      chk("reset_state_w2", SB_W'(pack_dut2()), '0);
      chk("reset_pc_write", SB_W'(pc_write), SB_W'(1'b1));
    end
    rst_n = 1'b1;

    // T2..T6 directed table
    for (int i = 0; i < 28; i++) begin
      hold = vecs[i].hold; flush = vecs[i].flush; id_valid = vecs[i].vld;
      id_ctrl = vecs[i].ctrl; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      drive_data();
      run_cycle(1'b1, vecs[i]);
    end

    // reset asserted in the middle of a stall
    hold = 0; flush = 0; id_valid = 1; id_ctrl = LW; id_rs = 1; id_rt = 8; drive_data();
    run_cycle(1'b0, none);
    id_ctrl = RT; id_rs = 8; id_rt = 3; drive_data();
    #3;
    chk("stall_before_reset", SB_W'(pc_write), SB_W'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("midstall_reset_state", pack_dut(), '0);
    chk("midstall_reset_pc_write", SB_W'(pc_write), SB_W'(1'b1));
    @(posedge clk);
    #1;
    chk("midstall_reset_hold", pack_dut(), '0);
    model_reset();
    rst_n = 1'b1;
    run_cycle(1'b0, none);

    // random stream against the model
    for (int i = 0; i < 300; i++) begin
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_ctrl = 11'($urandom);
      if ($urandom_range(0, 1) == 1) id_ctrl[6] = 1'b1;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      drive_data();
      run_cycle(1'b0, none);
    end

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
